// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: imem request/grant/response, execute redirect, decode valid/ready.
// master = fetch unit side, slave = memory/core environment side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready,
    output misalign_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready,
    input  misalign_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: one outstanding imem request, one-entry decode buffer, redirect squash.
// Response lands in the buffer the cycle after rvalid; a new request issues only when the buffer is empty or draining.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.master    bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DROP, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic        inst_valid_q, inst_valid_nxt;
  logic [31:0] inst_data_q, inst_data_nxt;
  logic [31:0] inst_pc_q, inst_pc_nxt;
  logic        misalign_q, misalign_nxt;
  logic        req;
  logic        grant;
  logic        outstanding;

  assign req   = (state == FETCH) && (!inst_valid_q || bus.inst_ready);
  assign grant = req && bus.imem_gnt;

  assign bus.imem_req     = req;
  assign bus.imem_addr    = pc;
  assign bus.inst_valid   = inst_valid_q;
  assign bus.inst_data    = inst_data_q;
  assign bus.inst_pc      = inst_pc_q;
  assign bus.misalign_err = misalign_q;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_pc_nxt     = req_pc;
    inst_valid_nxt = inst_valid_q;
    inst_data_nxt  = inst_data_q;
    inst_pc_nxt    = inst_pc_q;
    misalign_nxt   = misalign_q;
    outstanding    = 1'b0;

    if (inst_valid_q && bus.inst_ready) inst_valid_nxt = 1'b0;

    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (grant) begin
          req_pc_nxt  = pc;
          state_nxt   = WAIT;
          outstanding = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          inst_valid_nxt = 1'b1;
          inst_data_nxt  = bus.imem_rdata;
          inst_pc_nxt    = req_pc;
          pc_nxt         = req_pc + 32'd4;
          state_nxt      = FETCH;
        end else begin
          outstanding = 1'b1;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) state_nxt = FETCH;
        else                 outstanding = 1'b1;
      end
      ERR:     inst_valid_nxt = 1'b0;
      default: state_nxt = IDLE;
    endcase

    // Redirect wins over everything above; a response arriving with it is thrown away.
    if (bus.redirect_valid && state != ERR) begin
      inst_valid_nxt = 1'b0;
      inst_data_nxt  = inst_data_q;
      inst_pc_nxt    = inst_pc_q;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misalign_nxt = 1'b1;
        pc_nxt       = pc;
        state_nxt    = ERR;
      end else begin
        pc_nxt    = bus.redirect_pc;
        state_nxt = outstanding ? DROP : FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'h0;
      inst_pc_q    <= 32'h0;
      misalign_q   <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      req_pc       <= req_pc_nxt;
      inst_valid_q <= inst_valid_nxt;
      inst_data_q  <= inst_data_nxt;
      inst_pc_q    <= inst_pc_nxt;
      misalign_q   <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small imem responder (rdata = addr ^ A5A5A5A5).
module tb_instr_fetch_unit;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic gnt_en = 1'b1;
  int   lat    = 1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] gnt_addr_q[$];
  int          gnt_cyc_q[$];
  logic [63:0] cons_q[$];

  logic [31:0] exp_pc  [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] exp_dat [4] = '{32'hA5A5_A5A5, 32'hA5A5_A5A1, 32'hA5A5_A5AD, 32'hA5A5_A5A9};

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_gnt = gnt_en;

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // imem responder plus grant/consume monitor; drives at +2, samples at +8 of each cycle
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] a_q;
    logic        seen;
    logic [31:0] seen_addr;
    pend = 1'b0; cnt = 0; a_q = '0; seen = 1'b0; seen_addr = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      bus.imem_rvalid = 1'b0;
      if (seen) begin
        pend = 1'b1;
        cnt  = lat;
        a_q  = seen_addr;
      end
      if (pend) begin
        if (cnt <= 1) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = a_q ^ 32'hA5A5_A5A5;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      #6;
      seen      = bus.imem_req && bus.imem_gnt;
      seen_addr = bus.imem_addr;
      if (seen) begin
        gnt_addr_q.push_back(bus.imem_addr);
        gnt_cyc_q.push_back(cyc);
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid && !reset)
        cons_q.push_back({bus.inst_pc, bus.inst_data});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    gnt_addr_q.delete();
    gnt_cyc_q.delete();
    cons_q.delete();
  endtask

  task automatic wait_req(input logic [31:0] a, input string tag);
    for (int i = 0; i < 30; i++) begin
      tick;
      #4;
      if (bus.imem_req && bus.imem_addr == a) break;
    end
    chk(tag, {bus.imem_req, bus.imem_addr}, {1'b1, a});
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30; i++) begin
      tick;
      #4;
      if (bus.inst_valid) break;
    end
    chk(tag, bus.inst_valid, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   bus.imem_req,     1'b0);
    chk({tag, "_addr"},  bus.imem_addr,    32'h0);
    chk({tag, "_valid"}, bus.inst_valid,   1'b0);
    chk({tag, "_data"},  bus.inst_data,    32'h0);
    chk({tag, "_pc"},    bus.inst_pc,      32'h0);
    chk({tag, "_err"},   bus.misalign_err, 1'b0);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b1;

    // reset values, then IDLE for one cycle, first request in the next
    #1 reset = 1'b1;
    #2;
    chk_reset_outputs("rst");
    tick;
    reset = 1'b0;
    #4;
    chk("idle_no_req", bus.imem_req, 1'b0);
    tick;
    #4;
    chk("first_req", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0});

    // zero-wait streaming
    for (int i = 0; i < 40 && cons_q.size() < 4; i++) tick;
    chk("p1_ncons", cons_q.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("p1_gnt_addr", gnt_addr_q[i], exp_pc[i]);
      chk("p1_cons", cons_q[i], {exp_pc[i], exp_dat[i]});
    end
    for (int i = 0; i < 3; i++)
      chk("p1_period", gnt_cyc_q[i+1] - gnt_cyc_q[i], 2);

    // decode stall holds the buffer and blocks requests
    bus.inst_ready = 1'b0;
    do_reset;
    wait_valid("p2_first_valid");
    for (int i = 0; i < 5; i++) begin
      chk("p2_hold_valid", bus.inst_valid, 1'b1);
      chk("p2_hold_pc",    bus.inst_pc,    32'h0);
      chk("p2_hold_data",  bus.inst_data,  32'hA5A5_A5A5);
      chk("p2_hold_noreq", bus.imem_req,   1'b0);
      tick;
      #4;
    end
    bus.inst_ready = 1'b1;
    #1;
    chk("p2_release_req", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h4});

    // slow response squashed by a redirect
    wait_req(32'h8, "p3_req8");
    lat = 4;
    tick;
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick;
    bus.redirect_valid = 1'b0;
    #4;
    chk("p3_drop_noreq",  bus.imem_req,   1'b0);
    chk("p3_drop_valid",  bus.inst_valid, 1'b0);
    tick;
    #4;
    chk("p3_late_noreq",  bus.imem_req,   1'b0);
    chk("p3_late_valid",  bus.inst_valid, 1'b0);
    tick;
    #4;
    chk("p3_req100", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h100});
    chk("p3_req100_valid", bus.inst_valid, 1'b0);
    lat = 1;
    tick;
    #4;
    chk("p3_wait_valid", bus.inst_valid, 1'b0);
    tick;
    #4;
    chk("p3_inst", {bus.inst_valid, bus.inst_pc, bus.inst_data}, {1'b1, 32'h100, 32'hA5A5_A4A5});

    // redirect while buffered instruction is offered to decode
    bus.inst_ready = 1'b0;
    do_reset;
    wait_valid("p4_first_valid");
    bus.inst_ready = 1'b1;
    tick;
    bus.inst_ready = 1'b0;
    tick;
    #4;
    chk("p4_buf_pc4", {bus.inst_valid, bus.inst_pc}, {1'b1, 32'h4});
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    bus.inst_ready     = 1'b1;
    gnt_en             = 1'b0;
    tick;
    bus.redirect_valid = 1'b0;
    gnt_en             = 1'b1;
    #4;
    chk("p4_squash_valid", bus.inst_valid, 1'b0);
    chk("p4_req40", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h40});
    tick;
    tick;
    #4;
    chk("p4_inst", {bus.inst_valid, bus.inst_pc, bus.inst_data}, {1'b1, 32'h40, 32'hA5A5_A5E5});
    chk("p4_ncons", cons_q.size(), 1);

    // misaligned redirect is sticky until reset
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0102;
    tick;
    bus.redirect_valid = 1'b0;
    #4;
    chk("p5_err",     bus.misalign_err, 1'b1);
    chk("p5_noreq",   bus.imem_req,     1'b0);
    chk("p5_novalid", bus.inst_valid,   1'b0);
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick;
    bus.redirect_valid = 1'b0;
    #4;
    chk("p5_ignore_err",   bus.misalign_err, 1'b1);
    chk("p5_ignore_noreq", bus.imem_req,     1'b0);
    tick;
    #4;
    chk("p5_still_noreq",  bus.imem_req,     1'b0);
    chk("p5_still_valid",  bus.inst_valid,   1'b0);
    tick;
    reset = 1'b1;
    #1;
    chk("p5_rst_err", bus.misalign_err, 1'b0);
    gnt_en = 1'b0;
    tick;
    reset = 1'b0;
    wait_req(32'h0, "p5_restart");

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick;
    bus.redirect_valid = 1'b0;
    gnt_en             = 1'b1;
    #4;
    chk("p6_req_top", {bus.imem_req, bus.imem_addr}, {1'b1, 32'hFFFF_FFFC});
    tick;
    tick;
    #4;
    chk("p6_inst", {bus.inst_valid, bus.inst_pc, bus.inst_data}, {1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A59});
    chk("p6_wrap_req", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0});

    // reset in the middle of a wait; the stale response must be ignored
    lat = 4;
    tick;
    #4;
    chk("p7_wait_noreq", bus.imem_req, 1'b0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("p7_rst");
    tick;
    reset  = 1'b0;
    gnt_en = 1'b0;
    tick;
    tick;
    tick;
    #4;
    chk("p7_stale_valid", bus.inst_valid, 1'b0);
    tick;
    #4;
    chk("p7_stale_valid2", bus.inst_valid, 1'b0);
    chk("p7_req0", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0});
    lat    = 1;
    gnt_en = 1'b1;
    wait_valid("p7_valid");
    chk("p7_inst", {bus.inst_pc, bus.inst_data}, {32'h0, 32'hA5A5_A5A5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the RV32I single-cycle core. Holds the architectural PC, issues word fetches to instruction memory over a request/grant/response handshake, and buffers one fetched instruction toward decode with a valid/ready handshake. Accepts redirect targets (branch/jump next-PC) from the execute stage and squashes any in-flight or buffered fetch. Flags misaligned redirect targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (word-aligned).
- imem_gnt  in  1  memory accepted the request this cycle (imem_req & imem_gnt).
- imem_rvalid  in  1  response data valid; exactly one per granted request, 1 or more cycles after gnt.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- redirect_valid  in  1  one-cycle pulse: replace PC with redirect_pc.
- redirect_pc  in  32  redirect target (branch/jump next PC).
- inst_valid  out  1  inst_data/inst_pc hold a valid instruction.
- inst_data  out  32  buffered instruction word.
- inst_pc  out  32  address of inst_data.
- inst_ready  in  1  decode consumes the instruction when inst_valid & inst_ready.
- misalign_err  out  1  sticky: a redirect target had redirect_pc[1:0] != 0.

## Operation
- State: IDLE, FETCH, WAIT, DROP, ERR. Registers: pc, req_pc, one-entry buffer {inst_valid, inst_data, inst_pc}.
- IDLE: entered by reset; goes to FETCH unconditionally on the next edge.
- FETCH: imem_req = !inst_valid | inst_ready (buffer empty or draining this cycle); imem_addr = pc. On imem_req & imem_gnt: req_pc <= pc, go WAIT.
- WAIT: imem_req = 0. On imem_rvalid: buffer <= {1, imem_rdata, req_pc}; pc <= req_pc + 4 (32-bit, wraps FFFF_FFFC -> 0000_0000); go FETCH.
- Buffer: inst_valid cleared on inst_valid & inst_ready unless reloaded the same cycle. At most one request outstanding; a response always has buffer space.
- Redirect (highest priority, any state except ERR):
  - redirect_pc[1:0] != 0: misalign_err <= 1, inst_valid <= 0, go ERR; pc unchanged.
  - otherwise pc <= redirect_pc, inst_valid <= 0 (buffered instruction dropped, not consumed even if inst_ready).
  - next state: DROP if a request is outstanding after this edge (state WAIT without rvalid, or FETCH with imem_req & imem_gnt); else FETCH. A same-cycle rvalid in WAIT is discarded.
- DROP: imem_req = 0; on imem_rvalid discard data, go FETCH. A further redirect in DROP updates pc and stays in DROP.
- ERR: imem_req = 0, inst_valid = 0, redirects ignored; left only by reset.
- Request stability: while imem_req = 1 and imem_gnt = 0, imem_addr holds unless redirect_valid (new address next cycle).
- inst_data/inst_pc change only on buffer load; hold otherwise, including while stalled.

## Timing
- Reset values (asynchronous, while reset = 1): state IDLE, pc = RESET_PC, imem_req 0, imem_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0, misalign_err 0.
- First imem_req: second rising edge after reset release (IDLE, then FETCH).
- Grant in cycle N, rvalid in cycle N+k (k >= 1): inst_valid = 1 from cycle N+k+1; the next imem_req in cycle N+k+1 (when inst_ready = 1 or the buffer was empty).
- Zero-wait memory (gnt with req, rvalid next cycle): one instruction every 2 cycles.
- Redirect at edge E: inst_valid = 0 after E. With no outstanding request, imem_req with imem_addr = redirect_pc in cycle E+1. Otherwise, in the cycle after the discarded rvalid.
- imem_req and imem_addr are combinational from registered state and inst_valid/inst_ready. All other outputs are registered.

## Test plan
- Reset, then zero-wait memory returning rdata = addr ^ 32'hA5A5_A5A5, inst_ready = 1 -> addresses 0, 4, 8, 12 issued every 2 cycles; inst_pc sequence 0, 4, 8, 12 with matching inst_data.
- Hold inst_ready = 0 for 5 cycles after the first instruction -> inst_valid, inst_pc = 0 and inst_data held; imem_req = 0; after inst_ready = 1, the next request to address 4 in the same cycle.
- Grant addr 8 with rvalid delayed 3 cycles; redirect_pc = 32'h100 in the wait -> late rvalid data not presented; next request addr 0x100; inst_pc = 0x100.
- Redirect to 0x40 while the buffer holds the instruction at pc 4 and inst_ready = 1 same cycle -> that instruction is not consumed, inst_valid = 0 next cycle, next fetch from 0x40.
- Redirect to 32'h0000_0102 -> misalign_err = 1 sticky, imem_req = 0, no inst_valid; subsequent aligned redirects ignored; reset clears and fetch restarts at RESET_PC.
- Redirect to 32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000. Reset asserted mid-WAIT -> all outputs at reset values immediately, stale rvalid ignored.
